// File: rtl/bus_gate_reg_pkg.sv
// bus_gate_reg_pkg: shared types, constants and helpers for the registered
// multi-source bus gate.
//   sel_w()      - index width for an NCH-way selector (clog2, minimum 1)
//   bus_class_e  - per-cycle classification of the enable vector
//   CNT_MAX      - saturation value of the conflict counter at the default width
package bus_gate_reg_pkg;

    localparam int CNTW_DEF = 8;
    localparam int CNT_MAX  = (1 << CNTW_DEF) - 1;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_ONE   = 2'd1,
        BUS_MULTI = 2'd2
    } bus_class_e;

    // clog2 with a floor of 1 so a select port never collapses to zero bits
    function automatic int sel_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/bus_gate_reg_onehot_classify.sv
// onehot_classify: purely combinational classifier for the source enables.
//   en   in  NCH   per-channel enables
//   cls  out       BUS_NONE / BUS_ONE / BUS_MULTI
//   idx  out SELW  index of the set bit; meaningful only when cls == BUS_ONE
module onehot_classify
    import bus_gate_reg_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = 2
) (
    input  logic [NCH-1:0]  en,
    output bus_class_e      cls,
    output logic [SELW-1:0] idx
);

    int ones;

    always_comb begin
        ones = 0;
        idx  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (en[i]) begin
                ones = ones + 1;
                idx  = SELW'(i);
            end
        end
        if (ones == 0)      cls = BUS_NONE;
        else if (ones == 1) cls = BUS_ONE;
        else                cls = BUS_MULTI;
    end

endmodule

// File: rtl/bus_gate_reg.sv
// bus_gate_reg: registered bus driver for NCH enable-gated sources.
// Each source is ANDed with its enable, the gated values are ORed together and
// the result is registered (1-cycle latency). Cycles with more than one enable
// are flagged in a sticky conflict bit and a saturating counter.
//   clk, reset    clock, synchronous active-high reset
//   src_data      packed sources, channel i at [i*WIDTH +: WIDTH]
//   src_en        per-channel enables
//   conflict_clr  clears conflict / conflict_cnt (a same-cycle conflict wins)
//   bus_out       registered bus value
//   bus_valid     previous cycle had exactly one enabled source
//   bus_sel       index of that source
//   conflict      sticky multi-enable flag
//   conflict_cnt  saturating multi-enable count
module bus_gate_reg
    import bus_gate_reg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int HOLD  = 1,
    parameter int CNTW  = 8,
    localparam int SELW = sel_w(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] src_data,
    input  logic [NCH-1:0]       src_en,
    input  logic                 conflict_clr,
    output logic [WIDTH-1:0]     bus_out,
    output logic                 bus_valid,
    output logic [SELW-1:0]      bus_sel,
    output logic                 conflict,
    output logic [CNTW-1:0]      conflict_cnt
);

    localparam logic [CNTW-1:0] CNT_SAT = '1;

    bus_class_e       cls;
    logic [SELW-1:0]  idx;
    logic [WIDTH-1:0] merged;

    onehot_classify #(.NCH(NCH), .SELW(SELW)) u_cls (
        .en  (src_en),
        .cls (cls),
        .idx (idx)
    );

    // AND-gate each source with its enable, then wired-OR them together
    always_comb begin
        merged = '0;
        for (int i = 0; i < NCH; i++)
            merged = merged | (src_data[i*WIDTH +: WIDTH] & {WIDTH{src_en[i]}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_out      <= '0;
            bus_valid    <= 1'b0;
            bus_sel      <= '0;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            case (cls)
                BUS_ONE: begin
                    bus_out   <= merged;
                    bus_valid <= 1'b1;
                    bus_sel   <= idx;
                end
                BUS_MULTI: begin
                    // collided image kept on the bus for debug, never marked valid
                    bus_out   <= merged;
                    bus_valid <= 1'b0;
                end
                default: begin
                    bus_valid <= 1'b0;
                    if (HOLD == 0) bus_out <= '0;
                end
            endcase

            if (cls == BUS_MULTI) begin
                conflict <= 1'b1;
                // a clear in the same cycle restarts the count at this event
                if (conflict_clr)                 conflict_cnt <= CNTW'(1);
                else if (conflict_cnt != CNT_SAT) conflict_cnt <= conflict_cnt + CNTW'(1);
            end else if (conflict_clr) begin
                conflict     <= 1'b0;
                conflict_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_gate_reg.sv
module tb_bus_gate_reg;

    localparam int W = 16;
    localparam int N = 4;

    typedef struct {
        logic [W-1:0] out;
        logic         valid;
        logic [1:0]   sel;
        logic         conf;
        logic [7:0]   cnt;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_en;
    logic           conflict_clr;

    logic [W-1:0] a_out, b_out;
    logic         a_valid, b_valid;
    logic [1:0]   a_sel, b_sel;
    logic         a_conf, b_conf;
    logic [7:0]   a_cnt;
    logic [1:0]   b_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ma, mb;

    always #5 clk = ~clk;

    // A: holding bus, 8-bit counter
    bus_gate_reg #(.WIDTH(W), .NCH(N), .HOLD(1), .CNTW(8)) dut_a (
        .clk(clk), .reset(reset), .src_data(src_data), .src_en(src_en),
        .conflict_clr(conflict_clr), .bus_out(a_out), .bus_valid(a_valid),
        .bus_sel(a_sel), .conflict(a_conf), .conflict_cnt(a_cnt)
    );

    // B: legacy return-to-zero bus, 2-bit counter for saturation
    bus_gate_reg #(.WIDTH(W), .NCH(N), .HOLD(0), .CNTW(2)) dut_b (
        .clk(clk), .reset(reset), .src_data(src_data), .src_en(src_en),
        .conflict_clr(conflict_clr), .bus_out(b_out), .bus_valid(b_valid),
        .bus_sel(b_sel), .conflict(b_conf), .conflict_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input exp_t cur, input logic rst, input logic [N-1:0] en,
                                   input logic [N*W-1:0] d, input logic clr,
                                   input bit hold, input int cmax);
        exp_t nx;
        logic [W-1:0] m;
        int cnt_ones;
        nx = cur;
        m = '0;
        cnt_ones = $countones(en);
        for (int i = 0; i < N; i++) if (en[i]) m = m | d[i*W +: W];
        if (rst) begin
            nx = '{out: '0, valid: 1'b0, sel: '0, conf: 1'b0, cnt: '0};
        end else begin
            if (cnt_ones == 1) begin
                nx.out = m; nx.valid = 1'b1;
                for (int i = 0; i < N; i++) if (en[i]) nx.sel = 2'(i);
            end else if (cnt_ones == 0) begin
                nx.valid = 1'b0;
                if (!hold) nx.out = '0;
            end else begin
                nx.out = m; nx.valid = 1'b0;
            end
            if (cnt_ones >= 2) begin
                nx.conf = 1'b1;
                if (clr) nx.cnt = 8'd1;
                else if (int'(nx.cnt) < cmax) nx.cnt = nx.cnt + 8'd1;
            end else if (clr) begin
                nx.conf = 1'b0; nx.cnt = '0;
            end
        end
        return nx;
    endfunction

    task automatic compare_one(input string who, input exp_t e, input logic [W-1:0] o,
                               input logic v, input logic [1:0] s, input logic c,
                               input logic [7:0] k);
        chk({who, "_out"},   32'(o), 32'(e.out));
        chk({who, "_valid"}, 32'(v), 32'(e.valid));
        if (e.valid) chk({who, "_sel"}, 32'(s), 32'(e.sel));
        chk({who, "_conf"},  32'(c), 32'(e.conf));
        chk({who, "_cnt"},   32'(k), 32'(e.cnt));
    endtask

    // drive one cycle of stimulus, push the expected result, then check after the edge
    task automatic step(input logic rst, input logic [N-1:0] en, input logic [N*W-1:0] d,
                        input logic clr);
        exp_t ea, eb;
        reset = rst; src_en = en; src_data = d; conflict_clr = clr;
        ma = model(ma, rst, en, d, clr, 1'b1, 255);
        mb = model(mb, rst, en, d, clr, 1'b0, 3);
        qa.push_back(ma);
        qb.push_back(mb);
        @(posedge clk);
        #1;
        if (qa.size() == 0 || qb.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            compare_one("a", ea, a_out, a_valid, a_sel, a_conf, a_cnt);
            compare_one("b", eb, b_out, b_valid, b_sel, b_conf, {6'd0, b_cnt});
        end
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [N*W-1:0] d;
        ma = '{out: '0, valid: 1'b0, sel: '0, conf: 1'b0, cnt: '0};
        mb = ma;
        reset = 1'b1; src_en = '0; src_data = '0; conflict_clr = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 2; i++) step(1'b1, 4'($urandom), rnd_data(), 1'($urandom));
        chk("rst_out", 32'(a_out), 32'h0);
        chk("rst_cnt", 32'(a_cnt), 32'h0);

        // single source on channel 2
        d = rnd_data(); d[2*W +: W] = 16'hBEEF;
        step(1'b0, 4'b0100, d, 1'b0);
        chk("one_out", 32'(a_out), 32'hBEEF);
        chk("one_valid", 32'(a_valid), 32'h1);
        chk("one_sel", 32'(a_sel), 32'h2);

        // no source: hold vs return-to-zero
        step(1'b0, 4'b0000, rnd_data(), 1'b0);
        chk("none_hold", 32'(a_out), 32'hBEEF);
        chk("none_zero", 32'(b_out), 32'h0);
        chk("none_sel_hold", 32'(a_sel), 32'h2);

        // conflict between ch0 and ch3, then clear
        d = rnd_data(); d[0 +: W] = 16'h00F0; d[3*W +: W] = 16'h0F00;
        step(1'b0, 4'b1001, d, 1'b0);
        chk("multi_out", 32'(a_out), 32'h0FF0);
        chk("multi_conf", 32'(a_conf), 32'h1);
        chk("multi_cnt", 32'(a_cnt), 32'h1);
        step(1'b0, 4'b0000, rnd_data(), 1'b1);
        chk("clr_conf", 32'(a_conf), 32'h0);
        chk("clr_cnt", 32'(a_cnt), 32'h0);

        // saturation of the 2-bit counter: 1,2,3,3,3
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0011, rnd_data(), 1'b0);
            chk("sat_cnt", 32'(b_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        step(1'b0, 4'b1100, rnd_data(), 1'b1);
        chk("clr_multi_cnt", 32'(b_cnt), 32'h1);
        chk("clr_multi_conf", 32'(b_conf), 32'h1);
        step(1'b0, 4'b0000, rnd_data(), 1'b1);

        // walking one-hot sweep
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < N; c++) begin
                d = rnd_data();
                step(1'b0, 4'(1 << c), d, 1'b0);
                chk("sweep_out", 32'(a_out), 32'(d[c*W +: W]));
                chk("sweep_sel", 32'(a_sel), 32'(c));
                chk("sweep_conf", 32'(a_conf), 32'h0);
            end

        // reset mid-stream after valid traffic
        step(1'b0, 4'b0010, rnd_data(), 1'b0);
        step(1'b0, 4'b0110, rnd_data(), 1'b0);
        step(1'b1, 4'b1000, rnd_data(), 1'b0);
        chk("midrst_out", 32'(a_out), 32'h0);
        chk("midrst_valid", 32'(a_valid), 32'h0);
        chk("midrst_conf", 32'(a_conf), 32'h0);

        // random traffic against the model
        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 29) == 0), 4'($urandom), rnd_data(),
                 ($urandom_range(0, 7) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_gate_reg.md
Name: bus_gate_reg

Overview:
Parametrised, registered successor to the single-source 16-bit AND-gate bus buffer. It drives the shared MU0 data bus from NCH enable-gated sources, such as the ACC, PC, memory-read and PSEUDORAND generator outputs. The output is registered, and the block detects, counts and flags enable conflicts (more than one source enabled in the same cycle). It sits between the datapath register outputs and the bus consumer: ALU operand, memory write data, and IR load.

Parameters:
WIDTH, 16, data width of each source and of the bus
NCH, 4, number of gated sources (2..16)
HOLD, 1, 1 = bus keeps its last value when no source is enabled; 0 = bus returns to zero (legacy AND-gate behaviour)
CNTW, 8, width of the saturating conflict counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
src_data  in  NCH*WIDTH  packed source values; channel i occupies bits [i*WIDTH +: WIDTH]
src_en  in  NCH  per-channel enable (the "mux" gate of each source)
conflict_clr  in  1  clears the conflict flag and counter
bus_out  out  WIDTH  registered bus value
bus_valid  out  1  bus_out was driven by exactly one source in the previous cycle
bus_sel  out  clog2(NCH)  index of the source that produced bus_out (valid only when bus_valid=1)
conflict  out  1  sticky flag: at least one multi-enable cycle since the last clear
conflict_cnt  out  CNTW  saturating count of multi-enable cycles

Behaviour:
- Reset (synchronous, active-high):
  - bus_out=0, bus_valid=0, bus_sel=0, conflict=0, conflict_cnt=0.
  - Reset has priority over every other input; asserting it mid-stream discards the in-flight value.
- Combinational stage: gated_i = src_data[i] AND replicate(src_en[i]); merged = bitwise OR of all gated_i. With no enables, merged=0.
- Latency: exactly 1 clock from src_en/src_data to bus_out.
- Each rising edge, classify popcount(src_en):
  - ONE (exactly 1 enabled): bus_out <= merged; bus_valid <= 1; bus_sel <= index of the set bit.
  - NONE (0 enabled):
    - HOLD=1: bus_out holds its value.
    - HOLD=0: bus_out <= 0.
    - In both cases bus_valid <= 0 and bus_sel holds.
  - MULTI (2 or more enabled):
    - bus_out <= merged (wired-OR image of the colliding sources, for debug); bus_valid <= 0; bus_sel holds.
    - conflict <= 1.
    - conflict_cnt <= conflict_cnt+1, saturating at 2^CNTW-1 (no wrap).
- conflict_clr:
  - In a cycle with no MULTI: conflict <= 0 and conflict_cnt <= 0.
  - In the same cycle as a MULTI: the new event wins, giving conflict=1 and conflict_cnt=1.
- conflict and conflict_cnt are unaffected by ONE and NONE cycles.
- All state is held in flops; there are no latches and no combinational path from inputs to outputs.

Decomposition:
- A shared package holds:
  - the helper function for clog2(NCH)
  - an enum for the bus classification: BUS_NONE, BUS_ONE, BUS_MULTI
  - the constant CNT_MAX = 2^CNTW-1
- One natural sub-module, onehot_classify. It takes src_en and returns the class and the encoded index, and is purely combinational.
- The gating/OR tree and the registers stay in bus_gate_reg.

Test Plan:
1. Reset check: assert reset with random inputs for 2 cycles -> all outputs 0. Repeat with reset mid-stream after valid traffic -> outputs 0 on the next edge.
2. Single source: NCH=4, src_data ch2=16'hBEEF, src_en=4'b0100 -> the next cycle gives bus_out=16'hBEEF, bus_valid=1, bus_sel=2.
3. No source: after step 2, drive src_en=0 -> HOLD=1 gives bus_out=16'hBEEF with bus_valid=0; HOLD=0 gives bus_out=16'h0000 with bus_valid=0.
4. Conflict: ch0=16'h00F0, ch3=16'h0F00, src_en=4'b1001 -> bus_out=16'h0FF0, bus_valid=0, conflict=1, conflict_cnt=1. Then conflict_clr with src_en=0 -> conflict=0, conflict_cnt=0.
5. Saturation: CNTW=2, 5 consecutive MULTI cycles -> conflict_cnt goes 1,2,3,3,3. Simultaneous conflict_clr with a MULTI -> conflict_cnt=1.
6. Sweep: walking one-hot src_en across every channel with random data -> each cycle bus_out equals that channel's data delayed by one cycle, bus_sel equals the channel index, and conflict stays 0.
